// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
// Contents:
//   OP_LW / OP_SW    five-bit opcodes, taken from instruction bits [31:27]
//   state_t          FSM encoding: ST_IDLE, ST_REQ, ST_DONE
//   DEF_ADDR_W       default word-address width
//   DEF_TIMEOUT      default ack wait limit, in cycles
//   is_mem_opcode()  true when the opcode is a load or a store
package mem_defs;

  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_opcode(input logic [4:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_cells.sv
// Basic storage cells that hold the request and data registers.
// dffe_ref : one-bit flop with a write enable and an async active-low clear
//   clk    input  clock, rising edge
//   clr_n  input  asynchronous clear, active low
//   en     input  write enable
//   d      input  next value
//   q      output stored value
// register : WIDTH-bit register built from dffe_ref cells; ports as above
module dffe_ref (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)  q <= 1'b0;
    else if (en) q <= d;
  end

endmodule

module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dffe_ref u_bit (
      .clk  (clk),
      .clr_n(clr_n),
      .en   (en),
      .d    (d[g]),
      .q    (q[g])
    );
  end

endmodule

// File: rtl/mem_access_wait_counter.sv
// Cycle counter that times how long the stage has waited for a memory ack.
// Ports:
//   clk    input  clock, rising edge
//   clr_n  input  asynchronous clear, active low
//   en     input  count one cycle
//   sclr   input  synchronous clear; takes priority over en
//   tc     output high while enabled and the count equals TC_VAL
// The count stops at its all-ones value and never wraps.
module wait_counter #(
  parameter int WIDTH  = 8,
  parameter int TC_VAL = 254
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic sclr,
  output logic tc
);

  localparam logic [WIDTH-1:0] TCV  = WIDTH'(TC_VAL);
  localparam logic [WIDTH-1:0] MAXV = '1;

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                      r_cnt <= '0;
    else if (sclr)                   r_cnt <= '0;
    else if (en && (r_cnt != MAXV))  r_cnt <= r_cnt + WIDTH'(1);
  end

  assign tc = en && (r_cnt == TCV);

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage.
// Takes an instruction from the X/M pipe register. For an in-range lw or sw
// it holds a registered request on the data-memory port until the memory
// acks or the wait limit expires, and stalls the front of the pipeline while
// it waits. The result then goes to the M/W pipe register.
// Ports:
//   clk                   input   clock, rising edge
//   clr                   input   asynchronous reset, active low
//   xm_insn/alu/b         input   X/M instruction, ALU result, store data
//   xm_exception/overflow input   X/M exception flags
//   xm_valid              input   X/M holds a real instruction
//   mem_req/we/addr/wdata output  registered memory request
//   mem_ack               input   memory completion
//   mem_rdata             input   load data
//   mw_*                  output  M/W pipe values
//   stall                 output  freezes the upstream pipeline
module mem_access
  import mem_defs::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       xm_insn,
  input  logic [31:0]       xm_alu,
  input  logic [31:0]       xm_b,
  input  logic              xm_exception,
  input  logic              xm_overflow,
  input  logic              xm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mw_insn,
  output logic [31:0]       mw_alu,
  output logic [31:0]       mw_data,
  output logic              mw_exception,
  output logic              mw_overflow,
  output logic              mw_valid,
  output logic              stall
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      r_state;
  logic        r_timeout;
  logic [31:0] r_data;

  logic        w_is_mem;
  logic        w_is_sw;
  logic        w_in_range;
  logic        w_issue;
  logic        w_oor;
  logic        w_in_req;
  logic        w_tc;
  logic        w_finish;
  logic [31:0] w_cap;

  assign w_is_mem   = xm_valid && is_mem_opcode(xm_insn[31:27]);
  assign w_is_sw    = xm_insn[31:27] == OP_SW;
  assign w_in_range = xm_alu[31:ADDR_W] == '0;
  assign w_issue    = (r_state == ST_IDLE) && w_is_mem && w_in_range;
  assign w_oor      = (r_state == ST_IDLE) && w_is_mem && !w_in_range;
  assign w_in_req   = r_state == ST_REQ;
  // If the ack arrives on the terminal count it takes priority over the timeout.
  assign w_finish   = w_in_req && (mem_ack || w_tc);
  // Only a load that was acked returns data. A store or a timeout returns zero.
  assign w_cap      = (mem_ack && !mem_we) ? mem_rdata : 32'h0;

  wait_counter #(
    .WIDTH (CW),
    .TC_VAL(TIMEOUT - 1)
  ) u_wait (
    .clk  (clk),
    .clr_n(clr),
    .en   (w_in_req),
    .sclr (!w_in_req),
    .tc   (w_tc)
  );

  // mem_req is set on issue and cleared on finish. These events never coincide.
  dffe_ref u_req (
    .clk  (clk),
    .clr_n(clr),
    .en   (w_issue || w_finish),
    .d    (w_issue),
    .q    (mem_req)
  );

  dffe_ref u_we (
    .clk  (clk),
    .clr_n(clr),
    .en   (w_issue),
    .d    (w_is_sw),
    .q    (mem_we)
  );

  register #(.WIDTH(ADDR_W)) u_addr (
    .clk  (clk),
    .clr_n(clr),
    .en   (w_issue),
    .d    (xm_alu[ADDR_W-1:0]),
    .q    (mem_addr)
  );

  register #(.WIDTH(32)) u_wdata (
    .clk  (clk),
    .clr_n(clr),
    .en   (w_issue),
    .d    (xm_b),
    .q    (mem_wdata)
  );

  register #(.WIDTH(32)) u_data (
    .clk  (clk),
    .clr_n(clr),
    .en   (w_finish),
    .d    (w_cap),
    .q    (r_data)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= ST_IDLE;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_issue) r_state <= ST_REQ;
        ST_REQ: begin
          if (mem_ack) begin
            r_state <= ST_DONE;
          end else if (w_tc) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_timeout <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mw_insn     = xm_insn;
  assign mw_alu      = xm_alu;
  assign mw_overflow = xm_overflow;

  always_comb begin
    stall        = 1'b0;
    mw_valid     = xm_valid;
    mw_data      = 32'h0;
    mw_exception = xm_exception;
    case (r_state)
      ST_IDLE: begin
        stall = w_issue;
        if (w_oor) mw_exception = 1'b1;
      end
      ST_REQ: begin
        stall    = 1'b1;
        mw_valid = 1'b0;
      end
      ST_DONE: begin
        mw_data      = r_data;
        mw_exception = xm_exception || r_timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam int AW = 12;
  localparam logic [31:0] LW_I  = {5'b01000, 27'h0123456};
  localparam logic [31:0] SW_I  = {5'b00111, 27'h0654321};
  localparam logic [31:0] ADD_I = {5'b00000, 27'h0000ABC};

  logic          clk, clr;
  logic [31:0]   xm_insn, xm_alu, xm_b;
  logic          xm_exception, xm_overflow, xm_valid;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [31:0]   mw_insn, mw_alu, mw_data;
  logic          mw_exception, mw_overflow, mw_valid, stall;

  int total = 0;
  int bad   = 0;

  mem_access #(.ADDR_W(AW), .TIMEOUT(255)) dut (
    .clk(clk), .clr(clr),
    .xm_insn(xm_insn), .xm_alu(xm_alu), .xm_b(xm_b),
    .xm_exception(xm_exception), .xm_overflow(xm_overflow), .xm_valid(xm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mw_insn(mw_insn), .mw_alu(mw_alu), .mw_data(mw_data),
    .mw_exception(mw_exception), .mw_overflow(mw_overflow), .mw_valid(mw_valid),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    xm_valid = 1'b0; xm_insn = 32'h0; xm_alu = 32'h0; xm_b = 32'h0;
    xm_exception = 1'b0; xm_overflow = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] alu, input logic [31:0] b);
    xm_valid = 1'b1; xm_insn = insn; xm_alu = alu; xm_b = b;
  endtask

  // Keeps mem_req up and raises ack on REQ cycle ack_at (-1 means never).
  // Returns how many sampled cycles mem_req stayed high.
  task automatic run_long(input int ack_at, output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      mem_ack = (k == ack_at);
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    bubble(); xm_exception = 1'b1; clr = 1'b0; mem_rdata = 32'h0;
    #2;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h exp=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%0h exp=0", mem_wdata); end
    next_cycle(); next_cycle(); clr = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    total++; if (mw_valid !== 1'b0) begin bad++; $display("FAIL rst_mw_valid got=%0h exp=0", mw_valid); end
    total++; if (mw_data !== 32'h0) begin bad++; $display("FAIL rst_mw_data got=%0h exp=0", mw_data); end
    total++; if (mw_exception !== 1'b1) begin bad++; $display("FAIL rst_mw_exc got=%0h exp=1", mw_exception); end
    next_cycle(); bubble();
  endtask

  task automatic test_lw_fast();
    next_cycle(); issue(LW_I, 32'h10, 32'h0); xm_overflow = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_c0_stall got=%0h exp=1", stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_c0_req got=%0h exp=0", mem_req); end
    next_cycle(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_c1_stall got=%0h exp=1", stall); end
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010)
      begin bad++; $display("FAIL lw_c1_req got=%0h/%0h/%0h exp=1/0/10", mem_req, mem_we, mem_addr); end
    total++; if (mw_valid !== 1'b0) begin bad++; $display("FAIL lw_c1_mw_valid got=%0h exp=0", mw_valid); end
    next_cycle(); mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_c2_stall got=%0h exp=0", stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_c2_req got=%0h exp=0", mem_req); end
    total++; if (mw_valid !== 1'b1 || mw_data !== 32'hDEADBEEF)
      begin bad++; $display("FAIL lw_c2_data got=%0h/%0h exp=1/deadbeef", mw_valid, mw_data); end
    total++; if (mw_insn !== LW_I || mw_alu !== 32'h10 || mw_overflow !== 1'b1 || mw_exception !== 1'b0)
      begin bad++; $display("FAIL lw_c2_pass got=%0h/%0h/%0h/%0h", mw_insn, mw_alu, mw_overflow, mw_exception); end
    next_cycle(); bubble();
  endtask

  task automatic test_sw_slow();
    next_cycle(); issue(SW_I, 32'h20, 32'h12345678);
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); mem_ack = (k == 5); mem_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h020 || mem_wdata !== 32'h12345678 || stall !== 1'b1)
        begin bad++; $display("FAIL sw_req_c%0d got=%0h/%0h/%0h/%0h/%0h", k, mem_req, mem_we, mem_addr, mem_wdata, stall); end
    end
    next_cycle(); mem_ack = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || stall !== 1'b0 || mw_valid !== 1'b1 || mw_data !== 32'h0)
      begin bad++; $display("FAIL sw_done got=%0h/%0h/%0h/%0h exp=0/0/1/0", mem_req, stall, mw_valid, mw_data); end
    next_cycle(); bubble();
  endtask

  task automatic test_out_of_range();
    next_cycle(); issue(LW_I, 32'h00001000, 32'h0);
    @(negedge clk);
    total++; if (stall !== 1'b0 || mw_exception !== 1'b1 || mw_data !== 32'h0 || mw_valid !== 1'b1)
      begin bad++; $display("FAIL oor_c0 got=%0h/%0h/%0h/%0h exp=0/1/0/1", stall, mw_exception, mw_data, mw_valid); end
    next_cycle(); bubble();
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || stall !== 1'b0 || mw_exception !== 1'b0)
      begin bad++; $display("FAIL oor_c1 got=%0h/%0h/%0h exp=0/0/0", mem_req, stall, mw_exception); end
  endtask

  task automatic test_timeout();
    int n;
    next_cycle(); issue(LW_I, 32'h30, 32'h0); mem_rdata = 32'hFFFFFFFF;
    run_long(-1, n);
    total++; if (n !== 255) begin bad++; $display("FAIL to_req_cycles got=%0d exp=255", n); end
    total++; if (mw_exception !== 1'b1 || mw_data !== 32'h0 || mw_valid !== 1'b1 || stall !== 1'b0)
      begin bad++; $display("FAIL to_done got=%0h/%0h/%0h/%0h exp=1/0/1/0", mw_exception, mw_data, mw_valid, stall); end
    next_cycle(); bubble();
    @(negedge clk);
    total++; if (mw_exception !== 1'b0) begin bad++; $display("FAIL to_flag_clear got=%0h exp=0", mw_exception); end
  endtask

  task automatic test_ack_at_limit();
    int n;
    next_cycle(); issue(LW_I, 32'h34, 32'h0); mem_rdata = 32'hCAFEF00D;
    run_long(254, n);
    total++; if (n !== 255) begin bad++; $display("FAIL lim_req_cycles got=%0d exp=255", n); end
    total++; if (mw_exception !== 1'b0 || mw_data !== 32'hCAFEF00D)
      begin bad++; $display("FAIL lim_done got=%0h/%0h exp=0/cafef00d", mw_exception, mw_data); end
    next_cycle(); bubble();
  endtask

  task automatic test_reset_mid_req();
    next_cycle(); issue(LW_I, 32'h44, 32'h0);
    next_cycle();
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_pre_req got=%0h exp=1", mem_req); end
    next_cycle(); clr = 1'b0; bubble();
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_async_req got=%0h exp=0", mem_req); end
    next_cycle(); clr = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(negedge clk);
    total++; if (stall !== 1'b0 || mw_valid !== 1'b0 || mw_data !== 32'h0)
      begin bad++; $display("FAIL mid_after got=%0h/%0h/%0h exp=0/0/0", stall, mw_valid, mw_data); end
    next_cycle(); mem_ack = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || mw_data !== 32'h0)
      begin bad++; $display("FAIL mid_ack_ignored got=%0h/%0h exp=0/0", mem_req, mw_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [2];
    logic [31:0] ad [2];
    int stalls;
    rd[0] = 32'h11111111; rd[1] = 32'h22222222;
    ad[0] = 32'h40;       ad[1] = 32'h44;
    next_cycle(); issue(ADD_I, 32'h00ABCDEF, 32'h5);
    @(negedge clk);
    total++; if (stall !== 1'b0 || mw_valid !== 1'b1 || mw_data !== 32'h0 || mem_req !== 1'b0 || mw_alu !== 32'h00ABCDEF)
      begin bad++; $display("FAIL b2b_add got=%0h/%0h/%0h/%0h/%0h", stall, mw_valid, mw_data, mem_req, mw_alu); end
    for (int i = 0; i < 2; i++) begin
      stalls = 0;
      next_cycle(); issue(LW_I, ad[i], 32'h0);
      @(negedge clk); if (stall) stalls++;
      next_cycle(); mem_ack = 1'b1; mem_rdata = rd[i];
      @(negedge clk); if (stall) stalls++;
      total++; if (mem_addr !== ad[i][AW-1:0]) begin bad++; $display("FAIL b2b_addr%0d got=%0h exp=%0h", i, mem_addr, ad[i][AW-1:0]); end
      next_cycle(); mem_ack = 1'b0; mem_rdata = 32'h0;
      @(negedge clk); if (stall) stalls++;
      total++; if (stalls !== 2) begin bad++; $display("FAIL b2b_stalls%0d got=%0d exp=2", i, stalls); end
      total++; if (mw_data !== rd[i] || mw_valid !== 1'b1 || mw_alu !== ad[i])
        begin bad++; $display("FAIL b2b_data%0d got=%0h/%0h/%0h exp=%0h/1/%0h", i, mw_data, mw_valid, mw_alu, rd[i], ad[i]); end
    end
    next_cycle(); bubble();
  endtask

  initial begin
    test_reset();
    test_lw_fast();
    test_sw_slow();
    test_out_of_range();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_req();
    test_back_to_back();
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width driven to data memory.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles waited for mem_ack before abort.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low (clr=0 clears all state immediately).
REQ-005 xm_insn  input  32  instruction from X/M pipe; opcode = bits [31:27].
REQ-006 xm_alu  input  32  ALU result; effective word address for lw/sw.
REQ-007 xm_b  input  32  store data.
REQ-008 xm_exception, xm_overflow  input  1 each  flags from X/M pipe.
REQ-009 xm_valid  input  1  X/M pipe holds a real instruction (0 = bubble).
REQ-010 mem_req  output  1  registered memory request.
REQ-011 mem_we  output  1  registered write enable, valid while mem_req=1.
REQ-012 mem_addr  output  ADDR_W  registered word address, valid while mem_req=1.
REQ-013 mem_wdata  output  32  registered store data, valid while mem_req=1.
REQ-014 mem_ack  input  1  memory completion; valid only while mem_req=1.
REQ-015 mem_rdata  input  32  load data, sampled on the cycle mem_ack=1.
REQ-016 mw_insn, mw_alu, mw_data  output  32 each  to M/W pipe: instruction, ALU result, load data.
REQ-017 mw_exception, mw_overflow, mw_valid  output  1 each  to M/W pipe.
REQ-018 stall  output  1  combinational; freezes PC, F/D, D/X, X/M pipes and gates M/W write.

Function
REQ-019 A memory op is xm_valid=1 with opcode 5'b01000 (lw) or 5'b00111 (sw).
REQ-020 Address in range when xm_alu[31:ADDR_W]==0; mem_addr = xm_alu[ADDR_W-1:0].
REQ-021 FSM states: IDLE, REQ, DONE; reset state IDLE.
REQ-022 IDLE: in-range memory op -> stall=1, load mem_req=1, mem_we=(sw), mem_addr, mem_wdata; next REQ.
REQ-023 IDLE, non-memory op or bubble: stall=0, no request, outputs pass through, mw_data=0.
REQ-024 IDLE, out-of-range memory op: no request, stall=0, mw_exception=1, mw_data=0, stays IDLE.
REQ-025 REQ: stall=1, mw_valid=0, mem_req held with stable addr/we/wdata; wait counter increments each cycle.
REQ-026 REQ with mem_ack=1: capture mem_rdata (lw) or 0 (sw) into data register, drop mem_req next edge, go DONE.
REQ-027 REQ with counter==TIMEOUT-1 and mem_ack=0: set timeout flag, capture 0, drop mem_req, go DONE.
REQ-028 DONE: stall=0, mw_valid=1, mw_data=captured value, mw_exception=xm_exception|timeout flag; next IDLE, counter and flag cleared.
REQ-029 mw_insn, mw_alu, mw_overflow pass xm_* unmodified in all states; mw_valid=xm_valid outside REQ.
REQ-030 mem_ack outside REQ ignored; ack and timeout same cycle -> ack wins, no exception.
REQ-031 Minimum memory-op latency: arrives cycle 0, mem_req cycle 1, ack cycle 1, DONE cycle 2; stall high exactly cycles 0-1.
REQ-032 Counter width ceil(log2(TIMEOUT+1)); never wraps (saturates path exits to DONE).

Reset
REQ-033 clr=0: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data register 0, counter 0, timeout flag 0.
REQ-034 Reset mid-REQ drops mem_req asynchronously; in-flight ack after release is ignored.
REQ-035 Outputs after reset with xm_valid=0: stall=0, mw_valid=0, mw_data=0, mw_exception=xm_exception.

Structure
REQ-036 Shared package mem_defs holds OP_LW, OP_SW, state encodings, default ADDR_W and TIMEOUT.
REQ-037 One sub-module wait_counter: enable, synchronous clear, terminal-count output, async active-low clr.
REQ-038 Request/data registers built from the existing register and dffe_ref cells.

Verification
REQ-039 lw addr 0x10, ack on cycle 1 rdata 0xDEADBEEF -> stall cycles 0-1, DONE cycle 2 mw_data=0xDEADBEEF, mw_valid=1.
REQ-040 sw addr 0x20 data 0x12345678, ack after 5 cycles -> mem_we=1, mem_wdata=0x12345678 held stable 5 cycles, mw_data=0.
REQ-041 lw addr 0x00001000 -> no mem_req, stall=0, mw_exception=1 same cycle.
REQ-042 lw, no ack, TIMEOUT=255 -> mem_req high 255 cycles, DONE with mw_exception=1, mw_data=0.
REQ-043 clr=0 asserted during REQ, ack arrives after release -> mem_req=0 immediately, FSM IDLE, ack ignored.
REQ-044 add followed by back-to-back lw, lw -> add passes with stall=0; each lw stalls 2 cycles, data in order.
